// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch sequencer.
// Drives the PC register write port (pc_en/pc_next), issues req/ack fetches to
// instruction memory and presents each fetched word to decode via valid/ready.
// Branch/jump redirects take priority in every state; a redirect that lands
// while a request is outstanding parks the sequencer in DRAIN until the memory
// answers, because an issued request is never withdrawn.
//
// Build option: define FETCH_MISALIGN_TRAP_EN to add the fetch_err output and
// an ERR state that refuses to fetch from a PC whose bits [1:0] are non-zero.
// Without it, misaligned PCs fetch from the word address (bits [1:0] cleared).
module if_fetch_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic              pc_en,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              fetch_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OUT,
    S_DRAIN
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_ERR
`endif
  } state_t;

  state_t state;

  // Word-aligned request address straight from the PC register.
  // NOTE: imem_addr is the only unregistered output; a continuous assign
  // cannot infer a latch, so it needs no default handling.
  assign imem_addr = {pc_cur[ADDR_W-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  // PC value that will be live when the next REQ starts: if a write is in
  // flight this cycle, pc_cur has not caught up yet.
  logic [ADDR_W-1:0] pc_eff;
  logic              pc_misaligned;
  assign pc_eff        = pc_en ? pc_next : pc_cur;
  assign pc_misaligned = (pc_eff[1:0] != 2'b00);
`endif

  // Fetch state machine with fully registered outputs.
  // NOTE: every assignment here is non-blocking so all registers update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      imem_req   <= 1'b0;
      pc_en      <= 1'b0;
      pc_next    <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_err  <= 1'b0;
`endif
    end else begin
      // pc_en is a single-cycle pulse unless re-asserted below.
      pc_en <= 1'b0;

      if (redirect_valid) begin
        // Redirect wins over everything: write the target, drop any
        // pending instruction and suppress the sequential advance.
        pc_en      <= 1'b1;
        pc_next    <= redirect_pc;
        inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_err  <= 1'b0;
`endif
        if ((state == S_REQ || state == S_DRAIN) && !imem_ack) begin
          // Request still outstanding: keep it up and discard its data later.
          state    <= S_DRAIN;
          imem_req <= 1'b1;
        end else begin
          // Nothing outstanding (or it completes now and is discarded).
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pc_misaligned) begin
              state     <= S_ERR;
              fetch_err <= 1'b1;
              imem_req  <= 1'b0;
            end else begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end
`else
            state    <= S_REQ;
            imem_req <= 1'b1;
`endif
          end

          S_REQ: begin
            if (imem_ack) begin
              inst_out   <= imem_rdata;
              inst_pc    <= pc_cur;
              inst_valid <= 1'b1;
              pc_en      <= 1'b1;
              pc_next    <= pc_cur + ADDR_W'(PC_STEP);
              imem_req   <= 1'b0;
              state      <= S_OUT;
            end
          end

          S_OUT: begin
            if (inst_ready) begin
              inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
              if (pc_misaligned) begin
                state     <= S_ERR;
                fetch_err <= 1'b1;
                imem_req  <= 1'b0;
              end else begin
                state    <= S_REQ;
                imem_req <= 1'b1;
              end
`else
              state    <= S_REQ;
              imem_req <= 1'b1;
`endif
            end
          end

          S_DRAIN: begin
            // Stale response: swallow it and restart from the new PC.
            if (imem_ack) begin
              imem_req <= 1'b0;
              state    <= S_IDLE;
            end
          end

`ifdef FETCH_MISALIGN_TRAP_EN
          S_ERR: begin
            // Hold with no request until a redirect supplies a new PC.
            imem_req <= 1'b0;
          end
`endif

          default: begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
